muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencing controller between the EX stage and the shared multiplier/divider units. It accepts one MULT/MULTU/DIV/DIVU request at a time and registers the operands. It drives the start/sign/annul handshakes to the selected unit, raises the EX stall request until the HI/LO result is captured, and holds that result stable until the pipeline advances. It also blocks a held instruction from re-issuing, flushes cleanly and detects a hung unit with a watchdog.

Parameters:
DATA_W, 32, operand width; HI/LO are DATA_W each, unit results 2*DATA_W
TIMEOUT, 64, max cycles in a BUSY state before abort; 0 disables watchdog
DIV0_SHORTCUT, 1, 1 = divide-by-zero bypasses the divider and completes in 1 cycle

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  EX holds a mul/div instruction (level, held during stall)
req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
req_op1  in  DATA_W  rs value
req_op2  in  DATA_W  rt value
req_advance  in  1  EX register loads the next instruction this cycle
flush  in  1  kill current request
stallreq  out  1  stall request to the stall controller
res_valid  out  1  res_hi/res_lo valid; HI/LO write enable for the held instruction
res_hi  out  DATA_W  HI result (product high word / remainder)
res_lo  out  DATA_W  LO result (product low word / quotient)
timeout_err  out  1  one-cycle pulse on watchdog abort
mul_start  out  1  level start to multiplier
mul_sign  out  1  1 = signed multiply
mul_op1, mul_op2  out  DATA_W  multiplier operands
mul_ready  in  1  multiplier result valid, 1-cycle pulse
mul_result  in  2*DATA_W  {hi, lo}
div_start  out  1  level start to divider
div_signed  out  1  1 = signed divide
div_op1, div_op2  out  DATA_W  dividend, divisor
div_annul  out  1  abort divider
div_ready  in  1  divider result valid, 1-cycle pulse
div_result  in  2*DATA_W  {remainder, quotient}

Behaviour:
- Reset (rst=1 at edge): state IDLE, all registered outputs 0, operand registers 0, watchdog counter 0. Reset mid-operation drops the op. div_annul is combinational: asserted when state==DIV_BUSY & (flush | watchdog expiry), 0 otherwise (forced 0 during rst).
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- IDLE: if req_valid & ~flush, latch op1/op2/sign at the edge.
  - Next state is MUL_BUSY for req_op[1]=0 and DIV_BUSY for req_op[1]=1.
  - DIV with op2==0 and DIV0_SHORTCUT=1 goes to DONE, loading res_hi=op1, res_lo={DATA_W{1}}.
- BUSY: mul_start/div_start held high for the whole state; operands come from registers only and stay stable. The other unit's start is 0 with zero operands.
- mul_ready (MUL_BUSY) or div_ready (DIV_BUSY) seen: capture the result into res_hi/res_lo, go to DONE. Ready pulses arriving in the wrong state are ignored.
- DONE: res_valid=1, stallreq=0, results held. If req_advance, go to IDLE and clear res_valid at the edge. A held req_valid never restarts an op.
- stallreq (combinational) = req_valid & ~flush & (state != DONE). It is already 1 in the first cycle the instruction sits in EX.
- Latency: request seen in cycle 0, unit ready in cycle k → res_valid from cycle k+1; stall cycles = k+1. Divide-by-zero shortcut: 1 stall cycle.
- flush: any state goes to IDLE next edge and res_valid is cleared. Flush has priority over ready, timeout and advance.
- Watchdog: counter increments each BUSY cycle and is cleared on entering BUSY. At count==TIMEOUT-1 without ready:
  - div_annul is asserted if in DIV_BUSY;
  - the state goes to DONE with res_hi=res_lo=0;
  - timeout_err pulses 1 cycle.
  - Ready and expiry in the same cycle: ready wins.
- req_advance while in a BUSY state is illegal (stall asserted); the bench flags it as an assertion.
- DONE & req_advance with a new req_valid next cycle: IDLE accepts it normally, no bubble beyond the IDLE cycle.

Decomposition:
- Shared package holds:
  - op encodings (OP_MULT..OP_DIVU);
  - state encoding;
  - the DIV0 result constants;
  - the Stop/NoStop values already used by the stall controller.
- One natural sub-module: muldiv_watchdog (loadable up-counter with expiry flag, parameter TIMEOUT).

Test Plan:
- MULT op1=0xFFFFFFFD op2=5, mul_ready at cycle 4 → mul_sign=1; stallreq cycles 0..4; res_hi=0xFFFFFFFF res_lo=0xFFFFFFF1, res_valid from cycle 5.
- MULTU 0xFFFFFFFF×2 → res_hi=0x00000001 res_lo=0xFFFFFFFE; mul_start stays 0 after DONE while req_valid is held until req_advance.
- DIV 7 / 0xFFFFFFFE, div stub ready after 33 cycles → div_signed=1; res_lo=0xFFFFFFFD res_hi=0x00000001; exactly one start sequence.
- DIVU 0x1234 / 0 with DIV0_SHORTCUT=1 → div_start never 1; 1 stall cycle; res_hi=0x1234 res_lo=0xFFFFFFFF.
- DIV with flush in 3rd BUSY cycle, then ready same cycle → div_annul=1; IDLE next; res_valid stays 0; no HI/LO write.
- Divider stub never ready, TIMEOUT=8 → timeout_err pulse on the 9th cycle; res=0/0; stallreq drops; rst mid-MUL_BUSY → all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the EX-stage multiply/divide sequencing controller:
// instruction op encodings, controller state encoding, the divide-by-zero
// result constant and the stall-request levels used by the stall controller.
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  // req_op encodings as decoded by the EX stage.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MUL_BUSY = 2'b01,
    S_DIV_BUSY = 2'b10,
    S_DONE     = 2'b11
  } state_e;

  // x / 0 completes as HI = dividend, LO = every bit set to this value.
  localparam logic DIV0_LO_FILL = 1'b1;

  // Stall-request levels shared with the pipeline stall controller.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit 1 selects the divider, bit 0 selects the unsigned flavour.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
// Handshake bundle between the controller and the shared multiplier/divider.
//   master : controller side (drives start/sign/operands/annul)
//   slave  : unit side       (drives ready/result)
// Results are {hi, lo} for the multiplier and {remainder, quotient} for the
// divider, 2*DATA_W wide.
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if #(
  parameter int DATA_W = 32
) ();

  logic                mul_start;
  logic                mul_sign;
  logic [DATA_W-1:0]   mul_op1;
  logic [DATA_W-1:0]   mul_op2;
  logic                mul_ready;
  logic [2*DATA_W-1:0] mul_result;

  logic                div_start;
  logic                div_signed;
  logic [DATA_W-1:0]   div_op1;
  logic [DATA_W-1:0]   div_op2;
  logic                div_annul;
  logic                div_ready;
  logic [2*DATA_W-1:0] div_result;

  modport master (
    output mul_start, mul_sign, mul_op1, mul_op2,
    output div_start, div_signed, div_op1, div_op2, div_annul,
    input  mul_ready, mul_result, div_ready, div_result
  );

  modport slave (
    input  mul_start, mul_sign, mul_op1, mul_op2,
    input  div_start, div_signed, div_op1, div_op2, div_annul,
    output mul_ready, mul_result, div_ready, div_result
  );

endinterface

// File: rtl/muldiv_watchdog.sv
// -----------------------------------------------------------------------------
// muldiv_watchdog
// Up-counter that measures how long the controller has been waiting on a unit.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear the count (held while not waiting)
//   en_i       : count this cycle (controller is in a BUSY state)
//   expired_o  : this is the last allowed waiting cycle (count == TIMEOUT-1)
// TIMEOUT = 0 disables expiry altogether.
// -----------------------------------------------------------------------------
module muldiv_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_last;

  assign at_last   = (TIMEOUT > 0) && (count_q == LAST);
  assign expired_o = en_i && at_last;

  // NOTE: combinational next-state logic assigns a default first so no
  // path leaves count_d unassigned (which would infer a latch).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !at_last) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequences one MULT/MULTU/DIV/DIVU at a time from EX onto the shared
// multiplier or divider, stalls EX until HI/LO is captured, and holds the
// result (res_valid_o) until EX advances.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid_i     : EX holds a mul/div instruction (level)
//   req_op_i        : op_e encoding
//   req_op1_i/op2_i : rs / rt values
//   req_advance_i   : EX loads the next instruction this cycle
//   flush_i         : kill the current request
//   stallreq_o      : stall request to the stall controller
//   res_valid_o     : HI/LO write enable for the held instruction
//   res_hi_o/lo_o   : HI (product high / remainder), LO (product low / quotient)
//   timeout_err_o   : one-cycle pulse on watchdog abort
//   unit_if         : start/ready handshakes to the multiplier and divider
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int TIMEOUT       = 64,
  parameter int DIV0_SHORTCUT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_op1_i,
  input  logic [DATA_W-1:0] req_op2_i,
  input  logic              req_advance_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_hi_o,
  output logic [DATA_W-1:0] res_lo_o,
  output logic              timeout_err_o,
  muldiv_ctrl_if.master     unit_if
);

  state_e              state_q;
  logic                res_valid_q, timeout_err_q;
  logic [DATA_W-1:0]   res_hi_q, res_lo_q;
  logic                mul_start_q, mul_sign_q, div_start_q, div_signed_q;
  logic [DATA_W-1:0]   mul_op1_q, mul_op2_q, div_op1_q, div_op2_q;

  op_e                 op;
  logic                busy, wd_expired, unit_ready;
  logic [2*DATA_W-1:0] unit_result;

  assign op   = op_e'(req_op_i);
  assign busy = (state_q == S_MUL_BUSY) || (state_q == S_DIV_BUSY);

  // Only the ready of the unit we are waiting on counts; stray pulses from the
  // other unit, or while not busy, are ignored.
  assign unit_ready  = ((state_q == S_MUL_BUSY) && unit_if.mul_ready) ||
                       ((state_q == S_DIV_BUSY) && unit_if.div_ready);
  assign unit_result = (state_q == S_DIV_BUSY) ? unit_if.div_result : unit_if.mul_result;

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!busy),
    .en_i      (busy),
    .expired_o (wd_expired)
  );

  // The stall is already up in the first cycle the instruction sits in EX.
  assign stallreq_o = (req_valid_i && !flush_i && (state_q != S_DONE)) ? STOP : NO_STOP;

  // Ready beats expiry, so the divider is only annulled when it is abandoned.
  assign unit_if.div_annul = !rst && (state_q == S_DIV_BUSY) &&
                             (flush_i || (wd_expired && !unit_if.div_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      res_valid_q   <= 1'b0;
      res_hi_q      <= '0;
      res_lo_q      <= '0;
      timeout_err_q <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_sign_q    <= 1'b0;
      mul_op1_q     <= '0;
      mul_op2_q     <= '0;
      div_start_q   <= 1'b0;
      div_signed_q  <= 1'b0;
      div_op1_q     <= '0;
      div_op2_q     <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      if (flush_i) begin
        // Flush wins over ready, expiry and advance; HI/LO are never written.
        state_q     <= S_IDLE;
        res_valid_q <= 1'b0;
        mul_start_q <= 1'b0;
        div_start_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req_valid_i) begin
              if (!op_is_div(op)) begin
                state_q      <= S_MUL_BUSY;
                mul_start_q  <= 1'b1;
                mul_sign_q   <= op_is_signed(op);
                mul_op1_q    <= req_op1_i;
                mul_op2_q    <= req_op2_i;
                div_signed_q <= 1'b0;
                div_op1_q    <= '0;
                div_op2_q    <= '0;
              end else if ((DIV0_SHORTCUT != 0) && (req_op2_i == '0)) begin
                // The divider is never started for x / 0.
                state_q      <= S_DONE;
                res_valid_q  <= 1'b1;
                res_hi_q     <= req_op1_i;
                res_lo_q     <= {DATA_W{DIV0_LO_FILL}};
                mul_sign_q   <= 1'b0;
                mul_op1_q    <= '0;
                mul_op2_q    <= '0;
                div_signed_q <= 1'b0;
                div_op1_q    <= '0;
                div_op2_q    <= '0;
              end else begin
                state_q      <= S_DIV_BUSY;
                div_start_q  <= 1'b1;
                div_signed_q <= op_is_signed(op);
                div_op1_q    <= req_op1_i;
                div_op2_q    <= req_op2_i;
                mul_sign_q   <= 1'b0;
                mul_op1_q    <= '0;
                mul_op2_q    <= '0;
              end
            end
          end
          S_MUL_BUSY, S_DIV_BUSY: begin
            if (unit_ready) begin
              state_q     <= S_DONE;
              res_valid_q <= 1'b1;
              res_hi_q    <= unit_result[2*DATA_W-1:DATA_W];
              res_lo_q    <= unit_result[DATA_W-1:0];
              mul_start_q <= 1'b0;
              div_start_q <= 1'b0;
            end else if (wd_expired) begin
              state_q       <= S_DONE;
              res_valid_q   <= 1'b1;
              res_hi_q      <= '0;
              res_lo_q      <= '0;
              timeout_err_q <= 1'b1;
              mul_start_q   <= 1'b0;
              div_start_q   <= 1'b0;
            end
          end
          S_DONE: begin
            // A still-asserted req_valid belongs to the held instruction and
            // must not restart it; only advance releases the result.
            if (req_advance_i) begin
              state_q     <= S_IDLE;
              res_valid_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign res_valid_o        = res_valid_q;
  assign res_hi_o           = res_hi_q;
  assign res_lo_o           = res_lo_q;
  assign timeout_err_o      = timeout_err_q;
  assign unit_if.mul_start  = mul_start_q;
  assign unit_if.mul_sign   = mul_sign_q;
  assign unit_if.mul_op1    = mul_op1_q;
  assign unit_if.mul_op2    = mul_op2_q;
  assign unit_if.div_start  = div_start_q;
  assign unit_if.div_signed = div_signed_q;
  assign unit_if.div_op1    = div_op1_q;
  assign unit_if.div_op2    = div_op2_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl. dut_a uses the default watchdog (64);
// dut_b shares every input but uses TIMEOUT=8 for the watchdog scenario.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Cycle 0 of each scenario is the first cycle the request
// is presented.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_advance = 1'b0, flush = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_op1 = '0, req_op2 = '0;
  logic        mul_ready = 1'b0, div_ready = 1'b0;
  logic [63:0] mul_result = '0, div_result = '0;

  logic        stallreq, res_valid, timeout_err;
  logic [31:0] res_hi, res_lo;
  logic        stallreq_b, res_valid_b, timeout_err_b;
  logic [31:0] res_hi_b, res_lo_b;

  int errors = 0;
  int checks = 0;

  muldiv_ctrl_if #(.DATA_W(32)) ifa ();
  muldiv_ctrl_if #(.DATA_W(32)) ifb ();

  assign ifa.mul_ready  = mul_ready;
  assign ifa.mul_result = mul_result;
  assign ifa.div_ready  = div_ready;
  assign ifa.div_result = div_result;
  assign ifb.mul_ready  = mul_ready;
  assign ifb.mul_result = mul_result;
  assign ifb.div_ready  = div_ready;
  assign ifb.div_result = div_result;

  muldiv_ctrl #(.DATA_W(32), .TIMEOUT(64), .DIV0_SHORTCUT(1)) dut_a (
    .clk (clk), .rst (rst),
    .req_valid_i (req_valid), .req_op_i (req_op), .req_op1_i (req_op1), .req_op2_i (req_op2),
    .req_advance_i (req_advance), .flush_i (flush),
    .stallreq_o (stallreq), .res_valid_o (res_valid), .res_hi_o (res_hi), .res_lo_o (res_lo),
    .timeout_err_o (timeout_err), .unit_if (ifa)
  );

  muldiv_ctrl #(.DATA_W(32), .TIMEOUT(8), .DIV0_SHORTCUT(1)) dut_b (
    .clk (clk), .rst (rst),
    .req_valid_i (req_valid), .req_op_i (req_op), .req_op1_i (req_op1), .req_op2_i (req_op2),
    .req_advance_i (req_advance), .flush_i (flush),
    .stallreq_o (stallreq_b), .res_valid_o (res_valid_b), .res_hi_o (res_hi_b), .res_lo_o (res_lo_b),
    .timeout_err_o (timeout_err_b), .unit_if (ifb)
  );

  always #5 clk = ~clk;

  // Advancing EX while the controller still requests a stall is illegal.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(req_advance && stallreq))
        else $error("FAIL advance_while_stalled: req_advance=1 with stallreq=1");
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc(); smp();
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got=%b want=0", stallreq); end
    checks++; if ({res_valid, timeout_err, ifa.mul_start, ifa.div_start, ifa.div_annul} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=00000", {res_valid, timeout_err, ifa.mul_start, ifa.div_start, ifa.div_annul}); end
    checks++; if ({res_hi, res_lo, ifa.mul_op1, ifa.div_op2} !== 128'h0) begin
      errors++; $display("FAIL reset_data got=%h want=0", {res_hi, res_lo, ifa.mul_op1, ifa.div_op2}); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_mult();
    int stalls = 0;
    req_valid = 1'b1; req_op = OP_MULT; req_op1 = 32'hFFFF_FFFD; req_op2 = 32'd5;
    for (int c = 0; c <= 5; c++) begin
      mul_ready  = (c == 4);
      mul_result = (c == 4) ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0;
      smp();
      if (stallreq) stalls++;
      if (c == 1) begin
        checks++; if ({ifa.mul_start, ifa.mul_sign, ifa.div_start} !== 3'b110) begin
          errors++; $display("FAIL mult_start_sign got=%b want=110", {ifa.mul_start, ifa.mul_sign, ifa.div_start}); end
        checks++; if ({ifa.mul_op1, ifa.mul_op2} !== {32'hFFFF_FFFD, 32'h5}) begin
          errors++; $display("FAIL mult_operands got=%h want=fffffffd00000005", {ifa.mul_op1, ifa.mul_op2}); end
      end
      if (c == 4) begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mult_early_valid got=%b want=0", res_valid); end
      end
      if (c == 5) begin
        checks++; if ({res_valid, ifa.mul_start} !== 2'b10) begin
          errors++; $display("FAIL mult_done got=%b want=10", {res_valid, ifa.mul_start}); end
        checks++; if ({res_hi, res_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
          errors++; $display("FAIL mult_result got=%h want=fffffffffffffff1", {res_hi, res_lo}); end
      end
      cyc();
    end
    mul_ready = 1'b0;
    checks++; if (stalls != 5) begin errors++; $display("FAIL mult_stall_cycles got=%0d want=5", stalls); end
    req_advance = 1'b1;
    cyc();
    req_advance = 1'b0; req_valid = 1'b0;
    smp();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mult_advance_clear got=%b want=0", res_valid); end
    cyc();
  endtask

  task automatic test_multu_hold();
    req_valid = 1'b1; req_op = OP_MULTU; req_op1 = 32'hFFFF_FFFF; req_op2 = 32'd2;
    cyc();
    mul_ready = 1'b1; mul_result = 64'h0000_0001_FFFF_FFFE;
    smp();
    checks++; if ({ifa.mul_start, ifa.mul_sign} !== 2'b10) begin
      errors++; $display("FAIL multu_sign got=%b want=10", {ifa.mul_start, ifa.mul_sign}); end
    cyc();
    mul_ready = 1'b0;
    smp();
    checks++; if ({res_hi, res_lo} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("FAIL multu_result got=%h want=00000001fffffffe", {res_hi, res_lo}); end
    // req_valid stays high in DONE: no restart, result held, no stall.
    for (int c = 0; c < 4; c++) begin
      cyc(); smp();
      checks++; if ({ifa.mul_start, stallreq, res_valid} !== 3'b001) begin
        errors++; $display("FAIL multu_hold[%0d] start/stall/valid got=%b want=001", c, {ifa.mul_start, stallreq, res_valid}); end
    end
    cyc();
    req_advance = 1'b1;
    cyc();
    req_advance = 1'b0; req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_op = OP_MULT; req_op1 = 32'd3; req_op2 = 32'd4;
    cyc();
    mul_ready = 1'b1; mul_result = 64'd12;
    cyc();
    mul_ready = 1'b0; req_advance = 1'b1;
    smp();
    checks++; if ({res_valid, res_lo} !== {1'b1, 32'd12}) begin
      errors++; $display("FAIL b2b_first got=%h want=10000000c", {res_valid, res_lo}); end
    cyc();
    req_advance = 1'b0; req_op = OP_MULTU; req_op1 = 32'd6; req_op2 = 32'd7;
    smp();
    checks++; if ({res_valid, stallreq} !== 2'b01) begin
      errors++; $display("FAIL b2b_idle valid/stall got=%b want=01", {res_valid, stallreq}); end
    cyc();
    mul_ready = 1'b1; mul_result = 64'd42;
    smp();
    checks++; if ({ifa.mul_start, ifa.mul_sign, ifa.mul_op1} !== {2'b10, 32'd6}) begin
      errors++; $display("FAIL b2b_second_start got=%h want=200000006", {ifa.mul_start, ifa.mul_sign, ifa.mul_op1}); end
    cyc();
    mul_ready = 1'b0;
    smp();
    checks++; if ({res_valid, res_hi, res_lo} !== {1'b1, 64'd42}) begin
      errors++; $display("FAIL b2b_second_result got=%h want=1000000000000002a", {res_valid, res_hi, res_lo}); end
    req_advance = 1'b1;
    cyc();
    req_advance = 1'b0; req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_div();
    int stalls = 0;
    int starts = 0;
    logic prev_start = 1'b0;
    req_valid = 1'b1; req_op = OP_DIV; req_op1 = 32'd7; req_op2 = 32'hFFFF_FFFE;
    for (int c = 0; c <= 34; c++) begin
      div_ready  = (c == 33);
      div_result = (c == 33) ? {32'h0000_0001, 32'hFFFF_FFFD} : 64'h0;
      smp();
      if (stallreq) stalls++;
      if (ifa.div_start && !prev_start) starts++;
      prev_start = ifa.div_start;
      if (c == 1) begin
        checks++; if ({ifa.div_start, ifa.div_signed, ifa.mul_start, ifa.div_annul} !== 4'b1100) begin
          errors++; $display("FAIL div_start_signed got=%b want=1100", {ifa.div_start, ifa.div_signed, ifa.mul_start, ifa.div_annul}); end
        checks++; if ({ifa.div_op1, ifa.div_op2, ifa.mul_op1} !== {32'd7, 32'hFFFF_FFFE, 32'd0}) begin
          errors++; $display("FAIL div_operands got=%h want=00000007fffffffe00000000", {ifa.div_op1, ifa.div_op2, ifa.mul_op1}); end
      end
      if (c == 34) begin
        checks++; if ({res_valid, res_hi, res_lo} !== {1'b1, 32'h1, 32'hFFFF_FFFD}) begin
          errors++; $display("FAIL div_result got=%h want=100000001fffffffd", {res_valid, res_hi, res_lo}); end
      end
      cyc();
    end
    div_ready = 1'b0;
    checks++; if (stalls != 34) begin errors++; $display("FAIL div_stall_cycles got=%0d want=34", stalls); end
    checks++; if (starts != 1) begin errors++; $display("FAIL div_start_sequences got=%0d want=1", starts); end
    req_advance = 1'b1;
    cyc();
    req_advance = 1'b0; req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_div0();
    req_valid = 1'b1; req_op = OP_DIVU; req_op1 = 32'h0000_1234; req_op2 = 32'd0;
    smp();
    checks++; if ({stallreq, ifa.div_start} !== 2'b10) begin
      errors++; $display("FAIL div0_cycle0 stall/start got=%b want=10", {stallreq, ifa.div_start}); end
    cyc(); smp();
    checks++; if ({res_valid, stallreq, ifa.div_start} !== 3'b100) begin
      errors++; $display("FAIL div0_done valid/stall/start got=%b want=100", {res_valid, stallreq, ifa.div_start}); end
    checks++; if ({res_hi, res_lo} !== 64'h0000_1234_FFFF_FFFF) begin
      errors++; $display("FAIL div0_result got=%h want=00001234ffffffff", {res_hi, res_lo}); end
    cyc();
    req_advance = 1'b1;
    cyc();
    req_advance = 1'b0; req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_op = OP_DIV; req_op1 = 32'd100; req_op2 = 32'd7;
    cyc(); cyc(); smp();
    checks++; if ({ifa.div_start, ifa.div_annul} !== 2'b10) begin
      errors++; $display("FAIL flush_pre_annul got=%b want=10", {ifa.div_start, ifa.div_annul}); end
    cyc();
    flush = 1'b1; div_ready = 1'b1; div_result = {32'd2, 32'd14};
    smp();
    checks++; if ({ifa.div_annul, stallreq} !== 2'b10) begin
      errors++; $display("FAIL flush_annul annul/stall got=%b want=10", {ifa.div_annul, stallreq}); end
    cyc();
    flush = 1'b0; div_ready = 1'b0; req_valid = 1'b0;
    smp();
    checks++; if ({res_valid, ifa.div_start, ifa.div_annul, stallreq} !== 4'b0000) begin
      errors++; $display("FAIL flush_idle valid/start/annul/stall got=%b want=0000", {res_valid, ifa.div_start, ifa.div_annul, stallreq}); end
    cyc(); smp();
    checks++; if ({res_valid, res_lo} !== {1'b0, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL flush_no_write got=%h want=0ffffffff", {res_valid, res_lo}); end
    cyc();
  endtask

  task automatic test_reset_mid_mul();
    req_valid = 1'b1; req_op = OP_MULT; req_op1 = 32'h10; req_op2 = 32'h20;
    cyc(); smp();
    checks++; if ({ifa.mul_start, ifa.mul_op2} !== {1'b1, 32'h20}) begin
      errors++; $display("FAIL rstmid_busy got=%h want=100000020", {ifa.mul_start, ifa.mul_op2}); end
    cyc();
    rst = 1'b1; req_valid = 1'b0;
    cyc();
    rst = 1'b0;
    smp();
    checks++; if ({ifa.mul_start, ifa.mul_sign, ifa.div_start, res_valid, timeout_err, ifa.div_annul, stallreq} !== 7'b0) begin
      errors++; $display("FAIL rstmid_ctrl got=%b want=0000000",
        {ifa.mul_start, ifa.mul_sign, ifa.div_start, res_valid, timeout_err, ifa.div_annul, stallreq}); end
    checks++; if ({ifa.mul_op1, ifa.mul_op2, res_hi, res_lo} !== 128'h0) begin
      errors++; $display("FAIL rstmid_data got=%h want=0", {ifa.mul_op1, ifa.mul_op2, res_hi, res_lo}); end
    cyc();
  endtask

  task automatic test_timeout();
    // Load a non-zero HI/LO into dut_b first so the zeroed abort result shows.
    req_valid = 1'b1; req_op = OP_DIVU; req_op1 = 32'h55; req_op2 = 32'd0;
    cyc(); smp();
    checks++; if ({res_hi_b, res_lo_b} !== 64'h0000_0055_FFFF_FFFF) begin
      errors++; $display("FAIL wd_preload got=%h want=00000055ffffffff", {res_hi_b, res_lo_b}); end
    req_advance = 1'b1;
    cyc();
    req_advance = 1'b0; req_op = OP_DIV; req_op1 = 32'd9; req_op2 = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      smp();
      if (c == 7) begin
        checks++; if ({ifb.div_annul, timeout_err_b, stallreq_b} !== 3'b001) begin
          errors++; $display("FAIL wd_c7 annul/err/stall got=%b want=001", {ifb.div_annul, timeout_err_b, stallreq_b}); end
      end
      if (c == 8) begin
        checks++; if ({ifb.div_annul, timeout_err_b} !== 2'b10) begin
          errors++; $display("FAIL wd_c8 annul/err got=%b want=10", {ifb.div_annul, timeout_err_b}); end
      end
      if (c == 9) begin
        checks++; if ({timeout_err_b, res_valid_b, stallreq_b, ifb.div_start} !== 4'b1100) begin
          errors++; $display("FAIL wd_c9 err/valid/stall/start got=%b want=1100", {timeout_err_b, res_valid_b, stallreq_b, ifb.div_start}); end
        checks++; if ({res_hi_b, res_lo_b} !== 64'h0) begin
          errors++; $display("FAIL wd_result got=%h want=0", {res_hi_b, res_lo_b}); end
        checks++; if ({ifa.div_start, stallreq} !== 2'b11) begin
          errors++; $display("FAIL wd_long_timeout_still_busy got=%b want=11", {ifa.div_start, stallreq}); end
      end
      if (c == 10) begin
        checks++; if (timeout_err_b !== 1'b0) begin errors++; $display("FAIL wd_pulse_width got=%b want=0", timeout_err_b); end
      end
      cyc();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_hold();
    test_back_to_back();
    test_div();
    test_div0();
    test_flush();
    test_reset_mid_mul();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
